stencil_fetch: RTL and testbench

STENCIL_FETCH -- requirements
Module: stencil_fetch

---
 rtl/stencil_fetch_pkg.sv | 29 ++
 rtl/stencil_fetch_window.sv | 91 +++++++++
 rtl/stencil_fetch.sv | 188 ++++++++++++++++++
 tb/tb_stencil_fetch.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stencil_fetch_pkg.sv
// -----------------------------------------------------------------------------
// stencil_fetch_pkg
// Shared definitions for the stencil fetch block:
//   - signed 5.27 fixed-point format constants
//   - default grid geometry (rows per column, row address width)
//   - sweep FSM state encoding
// -----------------------------------------------------------------------------
package stencil_fetch_pkg;

    // Signed 5.27 fixed point: 1 sign bit, 4 integer bits, 27 fraction bits.
    localparam int                 DATA_W    = 32;
    localparam int                 FRAC_BITS = 27;
    localparam logic signed [31:0] FP_ONE    = 32'sh0800_0000;  // +1.0
    localparam logic signed [31:0] FP_SRC    = 32'sh4000_0000;  // +8.0
    localparam logic signed [31:0] FP_SNK    = 32'shC000_0000;  // -8.0

    // Default grid geometry: one M10K word per node, one column per M10K.
    localparam int DEF_NUM_ROWS = 256;
    localparam int DEF_ADDR_W   = 8;

    // Sweep FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : stencil_fetch_pkg

// File: rtl/stencil_fetch_window.sv
// -----------------------------------------------------------------------------
// stencil_window
// Row window for one column sweep. The center column forms a 3-entry window
// (down, center, up): the live M10K read data is the newest ("down") entry and
// two shift stages hold the center and up rows. Left and right column data
// have a 1-deep alignment register so they line up with the center row.
// The five stencil outputs are registered; edge substitution is applied on
// the way into the output registers.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_shift_en        shift new read data into the window
//   i_load_en         load the output registers with the current row
//   i_first_row       row being loaded is row 0           (up    := center)
//   i_last_row        row being loaded is the last row    (down  := center)
//   i_first_col       column sits on the left grid edge   (left  := center)
//   i_last_col        column sits on the right grid edge  (right := center)
//   i_q_left/center/right   read data from the three column M10Ks
//   o_node_*          registered stencil
// -----------------------------------------------------------------------------
module stencil_window
    import stencil_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_shift_en,
    input  logic              i_load_en,
    input  logic              i_first_row,
    input  logic              i_last_row,
    input  logic              i_first_col,
    input  logic              i_last_col,
    input  logic [DATA_W-1:0] i_q_left,
    input  logic [DATA_W-1:0] i_q_center,
    input  logic [DATA_W-1:0] i_q_right,
    output logic [DATA_W-1:0] o_node_center,
    output logic [DATA_W-1:0] o_node_up,
    output logic [DATA_W-1:0] o_node_down,
    output logic [DATA_W-1:0] o_node_left,
    output logic [DATA_W-1:0] o_node_right
);

    // r_c0: row r (becomes center), r_c1: row r-1 (becomes up).
    // i_q_center carries row r+1 (becomes down) in the load cycle.
    logic [DATA_W-1:0] r_c0;
    logic [DATA_W-1:0] r_c1;
    logic [DATA_W-1:0] r_l;
    logic [DATA_W-1:0] r_r;

    logic [DATA_W-1:0] r_center;
    logic [DATA_W-1:0] r_up;
    logic [DATA_W-1:0] r_down;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_right;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c0 <= '0;
            r_c1 <= '0;
            r_l  <= '0;
            r_r  <= '0;
        end else if (i_shift_en) begin
            r_c0 <= i_q_center;
            r_c1 <= r_c0;
            r_l  <= i_q_left;
            r_r  <= i_q_right;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_center <= '0;
            r_up     <= '0;
            r_down   <= '0;
            r_left   <= '0;
            r_right  <= '0;
        end else if (i_load_en) begin
            r_center <= r_c0;
            r_up     <= i_first_row ? r_c0 : r_c1;
            r_down   <= i_last_row  ? r_c0 : i_q_center;
            r_left   <= i_first_col ? r_c0 : r_l;
            r_right  <= i_last_col  ? r_c0 : r_r;
        end
    end

    assign o_node_center = r_center;
    assign o_node_up     = r_up;
    assign o_node_down   = r_down;
    assign o_node_left   = r_left;
    assign o_node_right  = r_right;

endmodule : stencil_window

// File: rtl/stencil_fetch.sv
// -----------------------------------------------------------------------------
// stencil_fetch
// Sweeps one grid column: reads rows 0..NUM_ROWS-1 from the left, center and
// right column M10Ks (shared address, 1-cycle read latency), presents one
// 5-point stencil per cycle to the compute stage and writes the compute
// result straight back to the destination column.
//
// Handshake: start is a one-cycle request, accepted only in IDLE (ignored
// while busy and in the DONE cycle). node_valid qualifies node_* and the
// write port; there is no backpressure, so rows stream without bubbles.
//
// Timing with T = start-accept cycle: rd_addr = k in cycle T+k (held at
// NUM_ROWS-1 afterwards), row r valid in cycle T+3+r, done in T+3+NUM_ROWS.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        sweep request
//   col_is_first / col_is_last   column on left / right grid edge
//   rd_addr                      shared read address
//   q_left / q_center / q_right  read data (signed 5.27)
//   node_center/up/down/left/right  registered stencil (signed 5.27)
//   node_valid                   stencil valid this cycle
//   new_center                   compute result for the current stencil
//   wr_en / wr_addr / wr_data    destination column write port
//   busy / done                  sweep in progress / end-of-sweep pulse
//   dbg_state                    current FSM state
// -----------------------------------------------------------------------------
module stencil_fetch
    import stencil_fetch_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              col_is_first,
    input  logic              col_is_last,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] q_left,
    input  logic [DATA_W-1:0] q_center,
    input  logic [DATA_W-1:0] q_right,
    output logic [DATA_W-1:0] node_center,
    output logic [DATA_W-1:0] node_up,
    output logic [DATA_W-1:0] node_down,
    output logic [DATA_W-1:0] node_left,
    output logic [DATA_W-1:0] node_right,
    output logic              node_valid,
    input  logic [DATA_W-1:0] new_center,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_row;       // row currently on node_*
    logic              r_fill;      // second FILL cycle
    logic              r_first_col;
    logic              r_last_col;
    logic              r_valid;

    logic              w_load_en;
    logic [ADDR_W-1:0] w_load_row;  // row entering the output registers
    logic              w_shift_en;
    logic              w_addr_step;
    logic [ADDR_W-1:0] w_rd_inc;

    // Next-state and window control.
    always_comb begin
        w_next     = r_state;
        w_load_en  = 1'b0;
        w_load_row = '0;
        w_shift_en = 1'b0;
        w_addr_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_FILL;
                    w_addr_step = 1'b1;
                end
            end
            ST_FILL: begin
                w_shift_en  = 1'b1;
                w_addr_step = 1'b1;
                // Row 0 is loaded as row 1 appears on the read port.
                if (r_fill) begin
                    w_next    = ST_RUN;
                    w_load_en = 1'b1;
                end
            end
            ST_RUN: begin
                w_shift_en  = 1'b1;
                w_addr_step = 1'b1;
                if (r_row == LAST_ROW) begin
                    w_next = ST_DONE;
                end else begin
                    w_load_en  = 1'b1;
                    w_load_row = r_row + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Saturating read address: stops at the last row while the pipe drains.
    assign w_rd_inc = (r_rd_addr == LAST_ROW) ? r_rd_addr : r_rd_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_row       <= '0;
            r_fill      <= 1'b0;
            r_first_col <= 1'b0;
            r_last_col  <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_load_en;
            if (w_load_en) begin
                r_row <= w_load_row;
            end
            if (w_addr_step) begin
                r_rd_addr <= w_rd_inc;
            end
            case (r_state)
                ST_IDLE: begin
                    r_fill <= 1'b0;
                    if (start) begin
                        r_first_col <= col_is_first;
                        r_last_col  <= col_is_last;
                    end
                end
                ST_FILL: begin
                    r_fill <= 1'b1;
                end
                ST_DONE: begin
                    // Park at row 0 so the next accept reads row 0 at once.
                    r_rd_addr <= '0;
                    r_row     <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    stencil_window u_window (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_shift_en   (w_shift_en),
        .i_load_en    (w_load_en),
        .i_first_row  (w_load_row == '0),
        .i_last_row   (w_load_row == LAST_ROW),
        .i_first_col  (r_first_col),
        .i_last_col   (r_last_col),
        .i_q_left     (q_left),
        .i_q_center   (q_center),
        .i_q_right    (q_right),
        .o_node_center(node_center),
        .o_node_up    (node_up),
        .o_node_down  (node_down),
        .o_node_left  (node_left),
        .o_node_right (node_right)
    );

    assign rd_addr    = r_rd_addr;
    assign node_valid = r_valid;
    assign wr_en      = r_valid;
    assign wr_addr    = r_row;
    assign wr_data    = new_center;
    assign busy       = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign dbg_state  = r_state;

endmodule : stencil_fetch

// File: tb/tb_stencil_fetch.sv
// -----------------------------------------------------------------------------
// tb_stencil_fetch
// Two instances: a 256-row column (dut_a) and a 2-row column (dut_b). Column
// M10Ks are modelled as arrays with a registered read port; the compute stage
// is a stub returning node_center + 1 LSB. Expected stencils are pushed when a
// start is issued and popped by per-instance monitors on node_valid / done.
// -----------------------------------------------------------------------------
module tb_stencil_fetch;
    import stencil_fetch_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] row;
        logic [31:0] up;
        logic [31:0] center;
        logic [31:0] down;
        logic [31:0] left;
        logic [31:0] right;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (256 rows) ----------------
    logic        a_start, a_first, a_last;
    logic [7:0]  a_rd_addr, a_wr_addr;
    logic [31:0] a_ql, a_qc, a_qr;
    logic [31:0] a_center, a_up, a_down, a_left, a_right, a_new_center, a_wr_data;
    logic        a_valid, a_wr_en, a_busy, a_done;
    state_t      a_state;
    logic [31:0] mem_a_l [0:255];
    logic [31:0] mem_a_c [0:255];
    logic [31:0] mem_a_r [0:255];

    always @(posedge clk) begin
        a_ql <= mem_a_l[a_rd_addr];
        a_qc <= mem_a_c[a_rd_addr];
        a_qr <= mem_a_r[a_rd_addr];
    end
    assign a_new_center = a_center + 32'd1;

    stencil_fetch #(.NUM_ROWS(256), .ADDR_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start),
        .col_is_first(a_first), .col_is_last(a_last), .rd_addr(a_rd_addr),
        .q_left(a_ql), .q_center(a_qc), .q_right(a_qr),
        .node_center(a_center), .node_up(a_up), .node_down(a_down),
        .node_left(a_left), .node_right(a_right), .node_valid(a_valid),
        .new_center(a_new_center), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .busy(a_busy), .done(a_done), .dbg_state(a_state)
    );

    // ---------------- DUT B (2 rows) ----------------
    logic        b_start, b_first, b_last;
    logic [0:0]  b_rd_addr, b_wr_addr;
    logic [31:0] b_ql, b_qc, b_qr;
    logic [31:0] b_center, b_up, b_down, b_left, b_right, b_new_center, b_wr_data;
    logic        b_valid, b_wr_en, b_busy, b_done;
    state_t      b_state;
    logic [31:0] mem_b_l [0:1];
    logic [31:0] mem_b_c [0:1];
    logic [31:0] mem_b_r [0:1];

    always @(posedge clk) begin
        b_ql <= mem_b_l[b_rd_addr];
        b_qc <= mem_b_c[b_rd_addr];
        b_qr <= mem_b_r[b_rd_addr];
    end
    assign b_new_center = b_center + 32'd1;

    stencil_fetch #(.NUM_ROWS(2), .ADDR_W(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start),
        .col_is_first(b_first), .col_is_last(b_last), .rd_addr(b_rd_addr),
        .q_left(b_ql), .q_center(b_qc), .q_right(b_qr),
        .node_center(b_center), .node_up(b_up), .node_down(b_down),
        .node_left(b_left), .node_right(b_right), .node_valid(b_valid),
        .new_center(b_new_center), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .busy(b_busy), .done(b_done), .dbg_state(b_state)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    int   done_a_q[$];
    int   done_b_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference stencil for row r of an n-row column.
    function automatic exp_t model(input int n, input int r, input int t,
                                   input logic fc, input logic lc,
                                   input logic [31:0] cm, input logic [31:0] cu,
                                   input logic [31:0] cd, input logic [31:0] lv,
                                   input logic [31:0] rv);
        exp_t e;
        e.cyc    = 32'(t + 3 + r);
        e.row    = 32'(r);
        e.center = cm;
        e.up     = (r == 0)     ? cm : cu;
        e.down   = (r == n - 1) ? cm : cd;
        e.left   = fc ? cm : lv;
        e.right  = lc ? cm : rv;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_a(input logic fc, input logic lc, output int t);
        a_start = 1'b1;
        a_first = fc;
        a_last  = lc;
        t = cyc;
        for (int r = 0; r < 256; r++) begin
            exp_a_q.push_back(model(256, r, t, fc, lc, mem_a_c[r],
                                    mem_a_c[(r == 0) ? 0 : r - 1],
                                    mem_a_c[(r == 255) ? 255 : r + 1],
                                    mem_a_l[r], mem_a_r[r]));
        end
        done_a_q.push_back(t + 3 + 256);
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_first = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic issue_b(input logic fc, input logic lc, output int t);
        b_start = 1'b1;
        b_first = fc;
        b_last  = lc;
        t = cyc;
        for (int r = 0; r < 2; r++) begin
            exp_b_q.push_back(model(2, r, t, fc, lc, mem_b_c[r],
                                    mem_b_c[0], mem_b_c[1],
                                    mem_b_l[r], mem_b_r[r]));
        end
        done_b_q.push_back(t + 3 + 2);
        @(posedge clk);
        #1;
        b_start = 1'b0;
        b_first = 1'b0;
        b_last  = 1'b0;
    endtask

    // ---------------- monitors ----------------
    exp_t ea;
    int   da;
    always @(negedge clk) begin
        if (a_wr_en !== a_valid) chk("a_wr_en_vs_valid", {31'b0, a_wr_en}, {31'b0, a_valid});
        if (a_valid) begin
            if (exp_a_q.size() == 0) begin
                chk("a_unexpected_row", {24'b0, a_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                ea = exp_a_q.pop_front();
                chk("a_row_cycle", 32'(cyc), ea.cyc);
                chk("a_wr_addr",   {24'b0, a_wr_addr}, ea.row);
                chk("a_up",        a_up,     ea.up);
                chk("a_center",    a_center, ea.center);
                chk("a_down",      a_down,   ea.down);
                chk("a_left",      a_left,   ea.left);
                chk("a_right",     a_right,  ea.right);
                chk("a_wr_data",   a_wr_data, ea.center + 32'd1);
            end
        end
        if (a_done) begin
            if (done_a_q.size() == 0) begin
                chk("a_unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                da = done_a_q.pop_front();
                chk("a_done_cycle", 32'(cyc), 32'(da));
                chk("a_done_busy",  {31'b0, a_busy},  32'd0);
                chk("a_done_valid", {31'b0, a_valid}, 32'd0);
            end
        end
    end

    exp_t eb;
    int   db;
    always @(negedge clk) begin
        if (b_valid) begin
            if (exp_b_q.size() == 0) begin
                chk("b_unexpected_row", {31'b0, b_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                eb = exp_b_q.pop_front();
                chk("b_row_cycle", 32'(cyc), eb.cyc);
                chk("b_wr_addr",   {31'b0, b_wr_addr}, eb.row);
                chk("b_up",        b_up,     eb.up);
                chk("b_center",    b_center, eb.center);
                chk("b_down",      b_down,   eb.down);
                chk("b_left",      b_left,   eb.left);
                chk("b_right",     b_right,  eb.right);
                chk("b_wr_en",     {31'b0, b_wr_en}, 32'd1);
                chk("b_wr_data",   b_wr_data, eb.center + 32'd1);
            end
        end
        if (b_done) begin
            if (done_b_q.size() == 0) begin
                chk("b_unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                db = done_b_q.pop_front();
                chk("b_done_cycle", 32'(cyc), 32'(db));
            end
        end
    end

    task automatic chk_a_zero(input string tag);
        chk({tag, "_rd_addr"}, {24'b0, a_rd_addr}, 32'd0);
        chk({tag, "_center"},  a_center, 32'd0);
        chk({tag, "_up"},      a_up,     32'd0);
        chk({tag, "_down"},    a_down,   32'd0);
        chk({tag, "_left"},    a_left,   32'd0);
        chk({tag, "_right"},   a_right,  32'd0);
        chk({tag, "_valid"},   {31'b0, a_valid}, 32'd0);
        chk({tag, "_wr_en"},   {31'b0, a_wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {24'b0, a_wr_addr}, 32'd0);
        chk({tag, "_busy"},    {31'b0, a_busy},  32'd0);
        chk({tag, "_done"},    {31'b0, a_done},  32'd0);
        chk({tag, "_state"},   {30'b0, a_state}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int t1, t2, t3, t4, tb1;

    initial begin
        for (int r = 0; r < 256; r++) begin
            mem_a_c[r] = 32'(r) << 27;          // r * FP_ONE
            mem_a_l[r] = 32'h0000_0000;
            mem_a_r[r] = 32'h1000_0000;         // 2.0
        end
        mem_b_c[0] = 32'h1111_1111; mem_b_c[1] = 32'h2222_2222;
        mem_b_l[0] = 32'hA000_0001; mem_b_l[1] = 32'hA000_0002;
        mem_b_r[0] = 32'h5000_0001; mem_b_r[1] = 32'h5000_0002;

        reset_n = 1'b0;
        a_start = 1'b0; a_first = 1'b0; a_last = 1'b0;
        b_start = 1'b0; b_first = 1'b0; b_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_a_zero("rst_a");
        chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
        chk("rst_b_busy",  {31'b0, b_busy},  32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Sweep 1: ramp, no edge flags.
        issue_a(1'b0, 1'b0, t1);
        wait_until(t1 + 8);
        @(negedge clk);
        chk("ramp_row5_up",     a_up,     32'h2000_0000);
        chk("ramp_row5_center", a_center, 32'h2800_0000);
        chk("ramp_row5_down",   a_down,   32'h3000_0000);
        chk("ramp_row5_left",   a_left,   32'h0000_0000);
        chk("ramp_row5_right",  a_right,  32'h1000_0000);
        chk("ramp_rd_addr_t8",  {24'b0, a_rd_addr}, 32'd8);
        chk("ramp_busy",        {31'b0, a_busy}, 32'd1);

        // Start while busy must be ignored (flags too).
        wait_until(t1 + 50);
        a_start = 1'b1; a_first = 1'b1; a_last = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0; a_first = 1'b0; a_last = 1'b0;

        // Start during the DONE cycle must be ignored.
        wait_until(t1 + 259);
        a_start = 1'b1;
        @(negedge clk);
        chk("done_cycle_done",    {31'b0, a_done}, 32'd1);
        chk("done_cycle_rd_addr", {24'b0, a_rd_addr}, 32'd255);
        chk("done_cycle_state",   {30'b0, a_state}, 32'd3);
        @(posedge clk);
        #1;

        // Sweep 2: accepted in the first IDLE cycle, both edge flags.
        issue_a(1'b1, 1'b1, t2);
        wait_until(t2 + 260);

        // Sweep 3: left edge only, aborted by reset at row 100.
        issue_a(1'b1, 1'b0, t3);
        wait_until(t3 + 103);
        reset_n = 1'b0;
        #1;
        chk_a_zero("abort_a");
        exp_a_q.delete();
        done_a_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Sweep 4: right edge only, first sweep after reset.
        issue_a(1'b0, 1'b1, t4);
        wait_until(t4 + 262);

        // Two-row column.
        issue_b(1'b0, 1'b0, tb1);
        wait_until(tb1 + 8);

        chk("a_rows_left_over", 32'(exp_a_q.size()),  32'd0);
        chk("a_done_left_over", 32'(done_a_q.size()), 32'd0);
        chk("b_rows_left_over", 32'(exp_b_q.size()),  32'd0);
        chk("b_done_left_over", 32'(done_b_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule : tb_stencil_fetch
